// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache miss
// controllers: one registered command at a time, response routed to the winner.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = 256,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic [STARVE_W-1:0]   starve_cnt_q,  starve_cnt_d;
  logic                  mem_read_q,    mem_read_d;
  logic                  mem_write_q,   mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q,   mem_wdata_d;

  logic i_req;
  logic d_req;
  logic d_wins;

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  // D is favoured under contention until it has starved I STARVE_LIMIT times in a row.
  assign d_wins = d_req & (~i_req | (starve_cnt_q < STARVE_MAX));

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (d_wins) begin
          mem_write_d   = d_pmem_write;
          mem_read_d    = d_pmem_read & ~d_pmem_write;
          mem_address_d = d_pmem_address;
          mem_wdata_d   = d_pmem_wdata;
          state_d       = SERVE_D;
          if (i_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (i_req) begin
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = i_pmem_address;
          starve_cnt_d  = '0;
          state_d       = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RECOVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  // Responses are gated by rst so a transaction interrupted by reset never completes.
  assign i_pmem_resp  = rst & mem_resp & (state_q == SERVE_I);
  assign d_pmem_resp  = rst & mem_resp & (state_q == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized checks of cache_arbiter against a transaction-level
// model of ownership, recovery gap and I-starvation streak.
module tb_cache_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned SL = 2;

  logic          clk;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  cache_arbiter #(
    .ADDR_WIDTH  (AW),
    .LINE_WIDTH  (LW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_resp      (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), idle gap after a
  // completion, and how many contended D grants have happened in a row.
  bit            mv = 0;
  int            owner = 0;
  int            gap = 0;
  int            streak = 0;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  int   dut_grants[$];
  logic prev_cmd = 1'b0;

  task automatic tick();
    bit ir, dr;
    #1;
    if (mv) begin
      check("i_resp",  i_pmem_resp, rst && owner == 1 && mem_resp);
      check("d_resp",  d_pmem_resp, rst && owner == 2 && mem_resp);
      check("mem_read",  mem_read,  m_read);
      check("mem_write", mem_write, m_write);
      check("mem_addr",  mem_address, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_rdata", i_pmem_rdata, mem_rdata);
      check("d_rdata", d_pmem_rdata, mem_rdata);
    end
    if ((mem_read | mem_write) && !prev_cmd) dut_grants.push_back(mem_write ? 2 : 1);
    prev_cmd = mem_read | mem_write;

    ir = i_pmem_read;
    dr = d_pmem_read | d_pmem_write;
    if (!rst) begin
      mv = 1; owner = 0; gap = 0; streak = 0;
      m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
    end else if (owner != 0) begin
      if (mem_resp) begin
        owner = 0; gap = 1; m_read = 0; m_write = 0;
      end
    end else if (gap > 0) begin
      gap--;
    end else if (dr && (!ir || streak < int'(SL))) begin
      owner = 2;
      m_write = d_pmem_write;
      m_read = d_pmem_read && !d_pmem_write;
      m_addr = d_pmem_address;
      m_wdata = d_pmem_wdata;
      if (ir && streak < int'(SL)) streak++;
    end else if (ir) begin
      owner = 1; m_read = 1; m_write = 0; m_addr = i_pmem_address; streak = 0;
    end
    @(negedge clk);
  endtask

  task automatic finish_txn();
    mem_resp = 1;
    tick();
    mem_resp = 0;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
    tick();
  endtask

  task automatic rand_line(output logic [LW-1:0] v);
    for (int unsigned k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
  endtask

  logic [LW-1:0] pat;
  logic [LW-1:0] cafe;
  int lat_cnt;
  int exp_order[6];

  initial begin
    rst = 0; i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    pat  = {8{32'hDEADBEEF}};
    cafe = {8{32'h0000CAFE}};
    @(negedge clk);

    // Reset with both requesters active
    i_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h80000020; d_pmem_wdata = cafe;
    tick(); tick();
    check("rst_read",  mem_read, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr",  mem_address, 0);
    check("rst_iresp", i_pmem_resp, 0);
    check("rst_dresp", d_pmem_resp, 0);
    rst = 1;
    tick();
    check("rel_write", mem_write, 1);
    finish_txn();

    // Lone I fill, memory answers three cycles after the command appears
    i_pmem_read = 1; i_pmem_address = 32'h00001A40;
    tick();
    check("ifill_read", mem_read, 1);
    check("ifill_addr", mem_address, 32'h00001A40);
    tick(); tick(); tick();
    i_pmem_read = 0; mem_rdata = pat; mem_resp = 1;
    #1;
    check("ifill_resp",  i_pmem_resp, 1);
    check("ifill_rdata", i_pmem_rdata, pat);
    check("ifill_dresp", d_pmem_resp, 0);
    tick();
    mem_resp = 0;
    check("ifill_drop", mem_read, 0);
    tick();

    // Contention: D first, then I after recovery
    i_pmem_read = 1; i_pmem_address = 32'h00000100;
    d_pmem_write = 1; d_pmem_address = 32'h80000020; d_pmem_wdata = cafe;
    tick();
    check("cont_dwrite", mem_write, 1);
    check("cont_dwdata", mem_wdata, cafe);
    check("cont_daddr",  mem_address, 32'h80000020);
    d_pmem_write = 0;
    tick();
    mem_resp = 1;
    #1;
    check("cont_dresp", d_pmem_resp, 1);
    check("cont_iresp", i_pmem_resp, 0);
    tick();
    mem_resp = 0;
    tick(); tick();
    check("cont_iread", mem_read, 1);
    check("cont_iaddr", mem_address, 32'h00000100);
    finish_txn();

    // Starvation: both held continuously, memory answers one cycle after command
    rst = 0; tick(); rst = 1;
    dut_grants.delete();
    i_pmem_read = 1; d_pmem_write = 1;
    lat_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      mem_resp = 0;
      if (mem_read | mem_write) begin
        lat_cnt++;
        if (lat_cnt == 2) begin mem_resp = 1; lat_cnt = 0; end
      end
      tick();
    end
    mem_resp = 0; i_pmem_read = 0; d_pmem_write = 0;
    tick(); tick(); tick();
    exp_order = '{2, 2, 1, 2, 2, 1};
    check("starve_cnt", (dut_grants.size() >= 6), 1);
    for (int k = 0; k < 6; k++) begin
      if (k < dut_grants.size()) check($sformatf("starve_grant%0d", k), dut_grants[k], exp_order[k]);
    end

    // Illegal D read+write: write wins
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h00002000;
    tick();
    check("ill_write", mem_write, 1);
    check("ill_read",  mem_read, 0);
    finish_txn();

    // Reset mid-transaction, then a stray mem_resp in IDLE
    d_pmem_write = 1; d_pmem_address = 32'h00003000;
    tick();
    check("mid_write", mem_write, 1);
    rst = 0; d_pmem_write = 0;
    tick();
    check("mid_drop",  mem_write, 0);
    rst = 1; mem_resp = 1;
    #1;
    check("late_iresp", i_pmem_resp, 0);
    check("late_dresp", d_pmem_resp, 0);
    tick();
    mem_resp = 0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [LW-1:0] r;
      rst          = ($urandom_range(0, 99) != 0);
      i_pmem_read  = ($urandom_range(0, 2) != 0);
      d_pmem_read  = ($urandom_range(0, 2) == 0);
      d_pmem_write = ($urandom_range(0, 2) == 0);
      i_pmem_address = $urandom;
      d_pmem_address = $urandom;
      rand_line(r); d_pmem_wdata = r;
      rand_line(r); mem_rdata = r;
      mem_resp = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
